// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 64;
    localparam int unsigned PIPE_CNT_W  = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Occupancy is encoded directly in the state value.
    function automatic logic [PIPE_CNT_W-1:0] state_count(pipe_state_e s);
        return PIPE_CNT_W'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage (upstream + downstream side).
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = pipe_pkg::PIPE_DATA_W
) ();
    import pipe_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [PIPE_CNT_W-1:0] count;

    // The stage itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    // The surroundings: upstream producer and downstream consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: single entry (SKID=0) or two-entry skid buffer (SKID=1).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned SKID   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             hold,
    pipe_stage_reg_if.slave  bus
);

    logic in_xfer;
    logic out_xfer;

    // Handshake qualifiers; hold and reset already gate ready/valid.
    assign in_xfer  = bus.in_valid  && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    if (SKID == 0) begin : g_single
        logic              valid_q, valid_d;
        logic [DATA_W-1:0] data_q,  data_d;

        // State register with synchronous reset.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        // Next state: flush clears, input replaces, lone output drains.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush) begin
                valid_d = 1'b0;
                data_d  = '0;
            end else if (in_xfer) begin
                valid_d = 1'b1;
                data_d  = bus.in_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
                data_d  = '0;
            end
        end

        assign bus.in_ready  = reset_n && !hold && (!valid_q || bus.out_ready);
        assign bus.out_valid = reset_n && !hold && valid_q;
        assign bus.out_data  = bus.out_valid ? data_q : '0;
        assign bus.count     = {1'b0, valid_q};
    end else begin : g_skid
        pipe_state_e       state_q, state_d;
        logic [DATA_W-1:0] data0_q, data0_d;  // output slot
        logic [DATA_W-1:0] data1_q, data1_d;  // skid slot

        // State register with synchronous reset.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q <= EMPTY;
                data0_q <= '0;
                data1_q <= '0;
            end else begin
                state_q <= state_d;
                data0_q <= data0_d;
                data1_q <= data1_d;
            end
        end

        // Next state: occupancy FSM; TWO drains by promoting the skid entry.
        always_comb begin
            state_d = state_q;
            data0_d = data0_q;
            data1_d = data1_q;
            if (flush) begin
                state_d = EMPTY;
                data0_d = '0;
                data1_d = '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            state_d = ONE;
                            data0_d = bus.in_data;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            data0_d = bus.in_data;
                        end else if (in_xfer) begin
                            state_d = TWO;
                            data1_d = bus.in_data;
                        end else if (out_xfer) begin
                            state_d = EMPTY;
                            data0_d = '0;
                        end
                    end
                    TWO: begin
                        if (out_xfer) begin
                            state_d = ONE;
                            data0_d = data1_q;
                            data1_d = '0;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                        data0_d = '0;
                        data1_d = '0;
                    end
                endcase
            end
        end

        // Ready depends only on state, never on out_ready.
        assign bus.in_ready  = reset_n && !hold && (state_q != TWO);
        assign bus.out_valid = reset_n && !hold && (state_q != EMPTY);
        assign bus.out_data  = bus.out_valid ? data0_q : '0;
        assign bus.count     = state_count(state_q);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid-buffer and single-entry variants side by side.
module tb_pipe_stage_reg;

    logic clk;
    logic reset_n;
    logic flush1, hold1;
    logic flush0, hold0;
    int   passed;
    int   total;

    pipe_stage_reg_if #(.DATA_W(64)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(64)) bus0 ();

    pipe_stage_reg #(.DATA_W(64), .SKID(1)) u_skid (
        .clk(clk), .reset_n(reset_n), .flush(flush1), .hold(hold1), .bus(bus1)
    );

    pipe_stage_reg #(.DATA_W(64), .SKID(0)) u_reg (
        .clk(clk), .reset_n(reset_n), .flush(flush0), .hold(hold0), .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 64'h1234; bus1.out_ready = 1'b1;
        bus0.in_valid = 1'b1; bus0.in_data = 64'h1234; bus0.out_ready = 1'b1;
        tick();
        tick();
        total++; if (bus1.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus1.out_valid); else passed++;
        total++; if (bus1.out_data !== 64'h0) $display("FAIL rst_out_data: got %h want 0", bus1.out_data); else passed++;
        total++; if (bus1.count !== 2'd0) $display("FAIL rst_count: got %0d want 0", bus1.count); else passed++;
        total++; if (bus1.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus1.in_ready); else passed++;
        total++; if (bus0.in_ready !== 1'b0) $display("FAIL rst_in_ready_s0: got %b want 0", bus0.in_ready); else passed++;
        reset_n = 1'b1;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        #1;
        total++; if (bus1.in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", bus1.in_ready); else passed++;
        total++; if (bus0.in_ready !== 1'b1) $display("FAIL rel_in_ready_s0: got %b want 1", bus0.in_ready); else passed++;
    endtask

    task automatic test_stream();
        bus1.out_ready = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_data = 64'h1;
        tick();
        bus1.in_data = 64'h2; #1;
        total++; if (bus1.out_data !== 64'h1 || bus1.out_valid !== 1'b1) $display("FAIL stream_d1: got %h/%b want 1/1", bus1.out_data, bus1.out_valid); else passed++;
        total++; if (bus1.count !== 2'd1) $display("FAIL stream_c1: got %0d want 1", bus1.count); else passed++;
        tick();
        bus1.in_data = 64'h3; #1;
        total++; if (bus1.out_data !== 64'h2) $display("FAIL stream_d2: got %h want 2", bus1.out_data); else passed++;
        total++; if (bus1.count !== 2'd1) $display("FAIL stream_c2: got %0d want 1", bus1.count); else passed++;
        tick();
        bus1.in_valid = 1'b0; #1;
        total++; if (bus1.out_data !== 64'h3) $display("FAIL stream_d3: got %h want 3", bus1.out_data); else passed++;
        total++; if (bus1.count !== 2'd1) $display("FAIL stream_c3: got %0d want 1", bus1.count); else passed++;
        tick();
        total++; if (bus1.out_valid !== 1'b0 || bus1.count !== 2'd0) $display("FAIL stream_empty: got %b/%0d want 0/0", bus1.out_valid, bus1.count); else passed++;
    endtask

    task automatic test_backpressure();
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 64'hA;
        tick();
        bus1.in_data = 64'hB; #1;
        total++; if (bus1.in_ready !== 1'b1 || bus1.count !== 2'd1) $display("FAIL bp_one: got rdy %b cnt %0d want 1/1", bus1.in_ready, bus1.count); else passed++;
        tick();
        bus1.in_valid = 1'b0; #1;
        total++; if (bus1.count !== 2'd2) $display("FAIL bp_count2: got %0d want 2", bus1.count); else passed++;
        total++; if (bus1.in_ready !== 1'b0) $display("FAIL bp_full_rdy: got %b want 0", bus1.in_ready); else passed++;
        total++; if (bus1.out_data !== 64'hA) $display("FAIL bp_head: got %h want a", bus1.out_data); else passed++;
        bus1.out_ready = 1'b1;
        tick();
        total++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 64'hB) $display("FAIL bp_promote: got %b/%h want 1/b", bus1.out_valid, bus1.out_data); else passed++;
        total++; if (bus1.in_ready !== 1'b1 || bus1.count !== 2'd1) $display("FAIL bp_drain1: got rdy %b cnt %0d want 1/1", bus1.in_ready, bus1.count); else passed++;
        tick();
        total++; if (bus1.out_valid !== 1'b0 || bus1.count !== 2'd0) $display("FAIL bp_drain2: got %b/%0d want 0/0", bus1.out_valid, bus1.count); else passed++;
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 64'hA;
        tick();
        bus1.in_data = 64'hB;
        tick();
        flush1 = 1'b1; bus1.in_data = 64'hC; #1;
        total++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 64'hA) $display("FAIL flush_shown: got %b/%h want 1/a", bus1.out_valid, bus1.out_data); else passed++;
        tick();
        flush1 = 1'b0; bus1.in_valid = 1'b0; #1;
        total++; if (bus1.count !== 2'd0) $display("FAIL flush_count: got %0d want 0", bus1.count); else passed++;
        total++; if (bus1.out_valid !== 1'b0 || bus1.out_data !== 64'h0) $display("FAIL flush_out: got %b/%h want 0/0", bus1.out_valid, bus1.out_data); else passed++;
        bus1.in_valid = 1'b1; bus1.in_data = 64'hD;
        tick();
        flush1 = 1'b1; bus1.in_data = 64'hC; #1;
        total++; if (bus1.in_ready !== 1'b1) $display("FAIL flush_acc_rdy: got %b want 1", bus1.in_ready); else passed++;
        tick();
        flush1 = 1'b0; bus1.in_valid = 1'b0; #1;
        total++; if (bus1.count !== 2'd0 || bus1.out_valid !== 1'b0) $display("FAIL flush_discard: got cnt %0d vld %b want 0/0", bus1.count, bus1.out_valid); else passed++;
    endtask

    task automatic test_hold();
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 64'h55;
        tick();
        bus1.in_valid = 1'b0; hold1 = 1'b1; bus1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus1.out_valid !== 1'b0) $display("FAIL hold_valid%0d: got %b want 0", i, bus1.out_valid); else passed++;
            total++; if (bus1.in_ready !== 1'b0) $display("FAIL hold_ready%0d: got %b want 0", i, bus1.in_ready); else passed++;
            total++; if (bus1.count !== 2'd1) $display("FAIL hold_count%0d: got %0d want 1", i, bus1.count); else passed++;
            tick();
        end
        hold1 = 1'b0; #1;
        total++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 64'h55) $display("FAIL hold_restore: got %b/%h want 1/55", bus1.out_valid, bus1.out_data); else passed++;
        tick();
        total++; if (bus1.count !== 2'd0 || bus1.out_valid !== 1'b0) $display("FAIL hold_once: got cnt %0d vld %b want 0/0", bus1.count, bus1.out_valid); else passed++;
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_flush_hold();
        bus1.in_valid = 1'b1; bus1.in_data = 64'h66;
        tick();
        bus1.in_valid = 1'b0; flush1 = 1'b1; hold1 = 1'b1;
        tick();
        flush1 = 1'b0; hold1 = 1'b0; #1;
        total++; if (bus1.count !== 2'd0 || bus1.out_valid !== 1'b0) $display("FAIL flush_hold: got cnt %0d vld %b want 0/0", bus1.count, bus1.out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 64'h11;
        tick();
        bus1.in_data = 64'h22;
        tick();
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; reset_n = 1'b0; #1;
        total++; if (bus1.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus1.out_valid); else passed++;
        tick();
        reset_n = 1'b1; bus1.out_ready = 1'b0; #1;
        total++; if (bus1.count !== 2'd0 || bus1.out_valid !== 1'b0) $display("FAIL rstmid_empty: got cnt %0d vld %b want 0/0", bus1.count, bus1.out_valid); else passed++;
    endtask

    task automatic test_replace();
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 64'h7;
        tick();
        total++; if (bus0.in_ready !== 1'b0) $display("FAIL s0_full_rdy: got %b want 0", bus0.in_ready); else passed++;
        bus0.in_data = 64'h8; bus0.out_ready = 1'b1; #1;
        total++; if (bus0.in_ready !== 1'b1) $display("FAIL s0_pass_rdy: got %b want 1", bus0.in_ready); else passed++;
        total++; if (bus0.out_data !== 64'h7 || bus0.count !== 2'd1) $display("FAIL s0_head: got %h/%0d want 7/1", bus0.out_data, bus0.count); else passed++;
        tick();
        bus0.in_valid = 1'b0; #1;
        total++; if (bus0.out_data !== 64'h8 || bus0.count !== 2'd1) $display("FAIL s0_replace: got %h/%0d want 8/1", bus0.out_data, bus0.count); else passed++;
        tick();
        total++; if (bus0.count !== 2'd0 || bus0.out_valid !== 1'b0 || bus0.out_data !== 64'h0) $display("FAIL s0_empty: got cnt %0d vld %b data %h want 0/0/0", bus0.count, bus0.out_valid, bus0.out_data); else passed++;
        bus0.out_ready = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        flush1 = 1'b0; hold1 = 1'b0;
        flush0 = 1'b0; hold0 = 1'b0;
        reset_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold();
        test_flush_hold();
        test_reset_mid();
        test_replace();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, meaning payload width in bits (instruction + PC for IF/ID use).
REQ-002 Parameter SKID, default 1, meaning 0 = single-entry register, 1 = two-entry skid buffer with registered in_ready.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  discard all held and incoming entries this cycle.
REQ-006 hold  input  1  freeze the stage; no transfer on either side.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  stage presents out_data.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  DATA_W  payload of oldest entry; all-zero (bubble) whenever out_valid=0.
REQ-013 count  output  2  number of valid entries held (0..1 if SKID=0, 0..2 if SKID=1).

Function
REQ-014 Input transfer occurs iff in_valid && in_ready; output transfer iff out_valid && out_ready; payload order strictly FIFO.
REQ-015 Latency: an entry accepted at edge N is presented on out_valid/out_data after edge N (one cycle); no combinational in_data->out_data path.
REQ-016 SKID=0: in_ready = !hold && (count==0 || out_ready); simultaneous in and out transfer replaces the entry, count stays 1.
REQ-017 SKID=1: states EMPTY(count 0), ONE(count 1), TWO(count 2); in_ready = !hold && state!=TWO, driven only from state (no out_ready path).
REQ-018 SKID=1 transitions: EMPTY->ONE on input transfer; ONE->TWO on input without output; ONE->EMPTY on output without input; ONE->ONE on both; TWO->ONE on output (no input possible).
REQ-019 In TWO, output transfer promotes the skid entry to the output slot in the same edge; out_valid stays 1 with no bubble.
REQ-020 hold=1: out_valid forced 0, in_ready forced 0, state and payload unchanged; out_valid/out_data restored on the cycle hold drops.
REQ-021 flush=1: at the next edge state->EMPTY, count->0, stored payloads zeroed; any input transfer in the flush cycle is discarded; out_valid is still shown for the flush cycle but an output transfer in that cycle is legal and counts.
REQ-022 flush and hold together: flush wins.
REQ-023 in_data is sampled only on accepted transfers; in_data while in_valid=0 has no effect.
REQ-024 Upstream keeps in_valid/in_data stable until accepted; behaviour otherwise unspecified but must not corrupt held entries.

Reset
REQ-025 While reset_n=0 at an edge: count=0, state EMPTY, stored payloads 0, out_valid=0, out_data=0.
REQ-026 in_ready=0 during any cycle in which reset_n=0; first acceptance possible in the cycle after reset_n rises.
REQ-027 Reset overrides flush, hold and all transfers; reset mid-operation discards all entries with no output transfer.

Structure
REQ-028 Shared package pipe_pkg holds the state enum (EMPTY/ONE/TWO) and constant PIPE_DATA_W=64.
REQ-029 Single module; no sub-module; SKID selects the generate branch, SKID=0 omits skid storage entirely.

Verification
REQ-030 Reset: hold reset_n=0 two cycles with in_valid=1, in_data=0x1234 -> out_valid=0, out_data=0, count=0, in_ready=0; cycle after release in_ready=1.
REQ-031 Streaming: SKID=1, out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, count=1 throughout.
REQ-032 Backpressure: SKID=1, out_ready=0, send 0xA,0xB -> count=2, in_ready=0; raise out_ready -> 0xA then 0xB with no bubble, in_ready=1 after first drain.
REQ-033 Flush: count=2 holding 0xA,0xB, flush=1 with in_valid=1, in_data=0xC -> next cycle count=0, out_valid=0, out_data=0; 0xC never appears.
REQ-034 Hold: count=1 holding 0x55, hold=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, count=1; hold=0 -> out_data=0x55 transferred once.
REQ-035 SKID=0 replace: count=1 holding 0x7, in_valid=1 data 0x8, out_ready=1 -> 0x7 consumed, next cycle out_data=0x8, count=1.
